amdc_adc_spi_emulator: RTL

//   Slave-side emulator of the AD4011 ADC serial port in the Kaman eddy current sensor (x and y channels).

---
 rtl/amdc_adc_spi_emulator.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/amdc_adc_spi_emulator.sv
// rtl/amdc_adc_spi_emulator.sv - AD4011 serial port emulator, two 18-bit channels on CNV/SCLK
module amdc_adc_spi_emulator #(
  parameter int DATA_W         = 18,
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_CNV_CYCLES = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cnv,
  input  logic              sclk,
  input  logic [DATA_W-1:0] sample_x,
  input  logic [DATA_W-1:0] sample_y,
  output logic              miso_x,
  output logic              miso_y,
  output logic              busy,
  output logic              frame_done,
  output logic              cnv_err,
  output logic              sclk_err
);

  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam int CNT_W = $clog2(MIN_CNV_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_SHIFT
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] cnv_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic                   cnv_dly;
  logic                   sclk_dly;
  logic                   cnv_rise;
  logic                   cnv_fall;
  logic                   sclk_fall;
  logic [DATA_W-1:0]      shadow_x;
  logic [DATA_W-1:0]      shadow_y;
  logic [CNT_W-1:0]       cnv_cnt;
  logic [BIT_W-1:0]       bit_cnt;

  // Bring the asynchronous master strobes into clk domain, plus one stage for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnv_sync  <= '0;
      sclk_sync <= '0;
      cnv_dly   <= 1'b0;
      sclk_dly  <= 1'b0;
    end else begin
      cnv_sync  <= {cnv_sync[SYNC_STAGES-2:0], cnv};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cnv_dly   <= cnv_sync[SYNC_STAGES-1];
      sclk_dly  <= sclk_sync[SYNC_STAGES-1];
    end
  end

  // Single-cycle edge strobes from the synchronised pins
  always_comb begin
    cnv_rise  = cnv_sync[SYNC_STAGES-1] & ~cnv_dly;
    cnv_fall  = ~cnv_sync[SYNC_STAGES-1] & cnv_dly;
    sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_dly;
  end

  // Conversion/shift FSM with all outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shadow_x   <= '0;
      shadow_y   <= '0;
      cnv_cnt    <= '0;
      bit_cnt    <= '0;
      miso_x     <= 1'b0;
      miso_y     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cnv_err    <= 1'b0;
      sclk_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cnv_err    <= 1'b0;
      sclk_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          miso_x <= 1'b0;
          miso_y <= 1'b0;
          if (sclk_fall) begin
            sclk_err <= 1'b1;
          end
          // A CNV rise while disabled is silently dropped
          if (cnv_rise && enable) begin
            state    <= ST_CONVERT;
            busy     <= 1'b1;
            shadow_x <= sample_x;
            shadow_y <= sample_y;
            cnv_cnt  <= '0;
          end
        end

        ST_CONVERT: begin
          if (sclk_fall) begin
            sclk_err <= 1'b1;
          end
          if (cnv_fall) begin
            if (cnv_cnt >= CNT_W'(MIN_CNV_CYCLES)) begin
              state   <= ST_SHIFT;
              bit_cnt <= '0;
              miso_x  <= shadow_x[DATA_W-1];
              miso_y  <= shadow_y[DATA_W-1];
            end else begin
              state   <= ST_IDLE;
              busy    <= 1'b0;
              cnv_err <= 1'b1;
              miso_x  <= 1'b0;
              miso_y  <= 1'b0;
            end
          end else if (cnv_cnt < CNT_W'(MIN_CNV_CYCLES)) begin
            cnv_cnt <= cnv_cnt + CNT_W'(1);
          end
        end

        ST_SHIFT: begin
          // A new conversion aborts the frame and takes priority over any coincident SCLK fall
          if (cnv_rise) begin
            cnv_err <= 1'b1;
            miso_x  <= 1'b0;
            miso_y  <= 1'b0;
            if (enable) begin
              state    <= ST_CONVERT;
              shadow_x <= sample_x;
              shadow_y <= sample_y;
              cnv_cnt  <= '0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else if (sclk_fall) begin
            if (bit_cnt == BIT_W'(DATA_W - 1)) begin
              state      <= ST_IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              miso_x     <= 1'b0;
              miso_y     <= 1'b0;
            end else begin
              shadow_x <= {shadow_x[DATA_W-2:0], 1'b0};
              shadow_y <= {shadow_y[DATA_W-2:0], 1'b0};
              bit_cnt  <= bit_cnt + BIT_W'(1);
              miso_x   <= shadow_x[DATA_W-2];
              miso_y   <= shadow_y[DATA_W-2];
            end
          end
        end

        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          miso_x <= 1'b0;
          miso_y <= 1'b0;
        end
      endcase
    end
  end

endmodule
